per_timer: RTL and testbench

Memory-mapped timer peripheral that sits on xSimBus as a responder (device) slot. A master reaches it through the bus device address/data path: xrv32i core loads and stores, gated by `select_as_in`. It provides a prescaled 32-bit up-counter, a compare match with optional auto-reload, a sticky match flag and a level interrupt output. It is the first writable bus device besides the core, and the bench template for later peripherals.

---
 rtl/per_timer_if.sv | 35 +++
 rtl/per_timer.sv | 144 ++++++++++++++
 tb/tb_per_timer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/per_timer_if.sv
// Bus-side types and the device-slot interface used by per_timer.
// A master drives select/address/data/direction and the timer answers with
// registered read data and a level interrupt.

package per_bus_pkg;
  typedef enum logic [1:0] {
    SelectAsNone   = 2'd0,
    SelectAsMaster = 2'd1,
    SelectAsDevice = 2'd2
  } select_mode_e;

  localparam logic RWInoutR = 1'b0;
  localparam logic RWInoutW = 1'b1;
endpackage

interface per_timer_if;
  import per_bus_pkg::*;

  select_mode_e select_as_in;
  logic [31:0]  addr_in;
  logic [31:0]  data_in;
  logic         rw_in;
  logic [31:0]  data_out;
  logic         irq_out;

  modport master (
    output select_as_in, addr_in, data_in, rw_in,
    input  data_out, irq_out
  );

  modport slave (
    input  select_as_in, addr_in, data_in, rw_in,
    output data_out, irq_out
  );
endinterface

// File: rtl/per_timer.sv
// Memory-mapped timer: prescaled 32-bit up-counter with compare match,
// optional auto-reload, sticky MATCH flag and a registered level interrupt.
// Register window is 32 bytes at BASE_ADDR; offsets are word indices 0..7.

module per_timer
  import per_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic   clk,
  input  logic   rst,
  per_timer_if.slave bus
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  // Architectural state
  logic [2:0]  ctrl_q;       // {IRQEN, AUTORELOAD, EN}
  logic [15:0] prescale_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        match_q;
  logic [15:0] pcnt_q;
  logic [31:0] data_q;
  logic        irq_q;

  // Next-state values
  logic [2:0]  ctrl_d;
  logic [15:0] prescale_d;
  logic [31:0] count_d;
  logic [31:0] compare_d;
  logic        match_d;
  logic [15:0] pcnt_d;
  logic [31:0] data_d;
  logic        irq_d;

  logic        hit;
  logic        wr;
  logic        rd;
  logic [2:0]  off;
  logic        tick;
  logic        match_set;
  logic [31:0] read_val;

  // Byte-lane bits of the address are not decoded.
  logic unused_addr;
  assign unused_addr = ^bus.addr_in[1:0];

  assign hit  = (bus.select_as_in == SelectAsDevice) &&
                (bus.addr_in[31:5] == BASE_ADDR[31:5]);
  assign off  = bus.addr_in[4:2];
  assign wr   = hit && (bus.rw_in == RWInoutW);
  assign rd   = hit && (bus.rw_in == RWInoutR);
  assign tick = ctrl_q[0] && (pcnt_q == prescale_q);

  // A bus write to COUNT pre-empts the tick, including its match check.
  assign match_set = tick && !(wr && off == OFF_COUNT) && (count_q == compare_q);

  // Read mux over the current (pre-update) register values.
  always_comb begin
    read_val = 32'h0;
    case (off)
      OFF_CTRL:     read_val = {29'h0, ctrl_q};
      OFF_PRESCALE: read_val = {16'h0, prescale_q};
      OFF_COUNT:    read_val = count_q;
      OFF_COMPARE:  read_val = compare_q;
      OFF_STATUS:   read_val = {31'h0, match_q};
      default:      read_val = 32'h0;
    endcase
  end

  // Next-state computation: prescaler/tick first, then bus writes override.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;
    pcnt_d     = pcnt_q;

    if (ctrl_q[0]) pcnt_d = tick ? 16'h0 : pcnt_q + 16'd1;

    if (tick) begin
      if (count_q == compare_q && ctrl_q[1]) count_d = 32'h0;
      else                                   count_d = count_q + 32'd1;
    end

    if (wr) begin
      case (off)
        OFF_CTRL: begin
          ctrl_d = bus.data_in[2:0];
          pcnt_d = 16'h0;
        end
        OFF_PRESCALE: begin
          prescale_d = bus.data_in[15:0];
          pcnt_d     = 16'h0;
        end
        OFF_COUNT:   count_d   = bus.data_in;
        OFF_COMPARE: compare_d = bus.data_in;
        OFF_STATUS:  if (bus.data_in[0]) match_d = 1'b0;
        default: ;
      endcase
    end

    // Set beats a simultaneous write-1-clear.
    if (match_set) match_d = 1'b1;

    data_d = rd ? read_val : 32'h0;
    irq_d  = match_d & ctrl_d[2];
  end

  // Register update with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ctrl_q     <= 3'h0;
      prescale_q <= 16'h0;
      count_q    <= 32'h0;
      compare_q  <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      pcnt_q     <= 16'h0;
      data_q     <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      pcnt_q     <= pcnt_d;
      data_q     <= data_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.irq_out  = irq_q;

endmodule

// File: tb/tb_per_timer.sv
// Self-checking bench for per_timer: directed scenarios followed by random
// bus traffic, all compared against a cycle-level behavioural model.

module tb_per_timer;
  import per_bus_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  per_timer_if bus ();

  per_timer #(.BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: register file plus elapsed enabled cycles in the
  // current prescale period.
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic        m_match;
  int          m_elapsed;
  logic [31:0] m_dout;
  logic        m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return {29'h0, m_ctrl};
      3'd1:    return {16'h0, m_pre};
      3'd2:    return m_count;
      3'd3:    return m_cmp;
      3'd4:    return {31'h0, m_match};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 3'h0; m_pre = 16'h0; m_count = 32'h0; m_cmp = 32'hFFFF_FFFF;
    m_match = 1'b0; m_elapsed = 0; m_dout = 32'h0; m_irq = 1'b0;
  endtask

  task automatic model_step(input select_mode_e sel, input logic [31:0] addr,
                            input logic rw, input logic [31:0] wd);
    logic       hit, wr, tick, hit_cmp;
    logic [2:0] off;
    logic [2:0] old_ctrl;
    hit      = (sel == SelectAsDevice) && (addr[31:5] == BASE[31:5]);
    off      = addr[4:2];
    wr       = hit && (rw == RWInoutW);
    m_dout   = (hit && rw == RWInoutR) ? model_read(off) : 32'h0;
    old_ctrl = m_ctrl;
    tick     = old_ctrl[0] && (m_elapsed == int'(m_pre));
    hit_cmp  = 1'b0;
    if (old_ctrl[0]) m_elapsed = tick ? 0 : m_elapsed + 1;
    if (wr && off == 3'd2) m_count = wd;
    else if (tick) begin
      hit_cmp = (m_count == m_cmp);
      m_count = (hit_cmp && old_ctrl[1]) ? 32'h0 : m_count + 32'd1;
    end
    if (wr && off == 3'd0) begin m_ctrl = wd[2:0]; m_elapsed = 0; end
    if (wr && off == 3'd1) begin m_pre = wd[15:0]; m_elapsed = 0; end
    if (wr && off == 3'd3) m_cmp = wd;
    if (wr && off == 3'd4 && wd[0]) m_match = 1'b0;
    if (hit_cmp) m_match = 1'b1;
    m_irq = m_match & m_ctrl[2];
  endtask

  // One bus cycle: drive between edges, step model at the edge, sample 1ns later.
  task automatic cyc(input string tag, input select_mode_e sel, input logic [31:0] addr,
                     input logic rw, input logic [31:0] wd);
    bus.select_as_in = sel;
    bus.addr_in      = addr;
    bus.rw_in        = rw;
    bus.data_in      = wd;
    @(posedge clk);
    model_step(sel, addr, rw, wd);
    #1;
    check({tag, ".dout"}, bus.data_out, m_dout);
    check({tag, ".irq"}, {31'h0, bus.irq_out}, {31'h0, m_irq});
  endtask

  task automatic wr(input string tag, input int off, input logic [31:0] d);
    cyc(tag, SelectAsDevice, BASE + 32'(off * 4), RWInoutW, d);
  endtask

  task automatic rd(input string tag, input int off);
    cyc(tag, SelectAsDevice, BASE + 32'(off * 4), RWInoutR, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", SelectAsNone, 32'h0, RWInoutR, 32'h0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    bus.select_as_in = SelectAsNone;
    bus.rw_in        = RWInoutR;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("rst.dout", bus.data_out, 32'h0);
    check("rst.irq", {31'h0, bus.irq_out}, 32'h0);
    #2 rst = 1'b0;
    idle(1);
  endtask

  initial begin
    logic [31:0] v;
    int          guard;
    select_mode_e rsel;
    int          roff;
    logic [31:0] rdat;
    logic        rrw;

    bus.select_as_in = SelectAsNone;
    bus.addr_in      = 32'h0;
    bus.data_in      = 32'h0;
    bus.rw_in        = RWInoutR;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and readback of the whole window.
    wr("pre_rst", 3, 32'h55);
    wr("pre_rst", 0, 32'h7);
    mid_reset();
    for (int i = 0; i < 8; i++) begin
      rd("rst_read", i);
      check("rst_val", bus.data_out, (i == 3) ? 32'hFFFF_FFFF : 32'h0);
    end

    // Prescaled counting; frozen while EN=0.
    wr("ps", 2, 32'h0);
    wr("ps", 1, 32'd3);
    idle(5);
    rd("ps_frozen", 2);
    check("ps_frozen_val", bus.data_out, 32'h0);
    wr("ps", 0, 32'h1);
    idle(40);
    rd("ps_cnt", 2);
    check("ps_cnt_range", {31'h0, (bus.data_out >= 32'd9 && bus.data_out <= 32'd11)}, 32'h1);

    // Compare with auto-reload and interrupt.
    wr("ar", 0, 32'h0);
    wr("ar", 1, 32'h0);
    wr("ar", 3, 32'd5);
    wr("ar", 2, 32'h0);
    wr("ar", 4, 32'h1);
    wr("ar", 0, 32'h7);
    for (int i = 0; i < 14; i++) rd("ar_count", 2);
    check("ar_irq_high", {31'h0, bus.irq_out}, 32'h1);
    wr("ar_clr", 4, 32'h1);
    rd("ar_after_clr", 4);
    idle(12);

    // Counter wrap without a flag.
    wr("wrap", 0, 32'h1);
    wr("wrap", 3, 32'd5);
    wr("wrap", 2, 32'hFFFF_FFFE);
    wr("wrap", 4, 32'h1);
    rd("wrap_r0", 2);
    check("wrap_v0", bus.data_out, 32'hFFFF_FFFF);
    rd("wrap_r1", 2);
    check("wrap_v1", bus.data_out, 32'h0);
    rd("wrap_r2", 2);
    check("wrap_v2", bus.data_out, 32'h1);
    rd("wrap_st", 4);
    check("wrap_match", bus.data_out, 32'h0);

    // Collisions: COUNT write on a tick edge, and clear on a match edge.
    wr("col_cnt", 2, 32'd100);
    rd("col_cnt_rd", 2);
    check("col_cnt_val", bus.data_out, 32'd100);
    wr("col", 0, 32'h3);
    wr("col", 2, 32'h0);
    guard = 0;
    while (m_count != m_cmp && guard < 20) begin
      idle(1);
      guard++;
    end
    check("col_wait_bound", {31'h0, (guard < 20)}, 32'h1);
    wr("col_clr", 4, 32'h1);
    rd("col_st", 4);
    check("col_match_set_wins", bus.data_out, 32'h1);

    // Decode and selection: misses must not change state and read 0.
    wr("dec", 0, 32'h0);
    rd("dec_before", 2);
    v = bus.data_out;
    cyc("dec_none", SelectAsNone, BASE + 32'h8, RWInoutW, 32'h1234);
    cyc("dec_master", SelectAsMaster, BASE + 32'h8, RWInoutW, 32'h1234);
    cyc("dec_off32", SelectAsDevice, BASE + 32'h28, RWInoutW, 32'h1234);
    wr("dec_off6", 6, 32'hDEAD_BEEF);
    cyc("dec_rd_none", SelectAsNone, BASE + 32'h8, RWInoutR, 32'h0);
    check("dec_rd_none_val", bus.data_out, 32'h0);
    cyc("dec_rd_off32", SelectAsDevice, BASE + 32'h28, RWInoutR, 32'h0);
    check("dec_rd_off32_val", bus.data_out, 32'h0);
    rd("dec_rd6", 6);
    check("dec_rd6_val", bus.data_out, 32'h0);
    rd("dec_after", 2);
    check("dec_count_kept", bus.data_out, v);

    // Random traffic, with one asynchronous reset in the middle.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) mid_reset();
      case ($urandom_range(0, 9))
        0:       rsel = SelectAsNone;
        1:       rsel = SelectAsMaster;
        default: rsel = SelectAsDevice;
      endcase
      roff = $urandom_range(0, 7);
      rrw  = ($urandom_range(0, 2) == 0) ? RWInoutW : RWInoutR;
      rdat = $urandom;
      if (roff == 1) rdat = 32'($urandom_range(0, 3)) | (rdat & 32'hFFFF_0000);
      if (roff == 2 || roff == 3) rdat = 32'($urandom_range(0, 12));
      if (roff == 4) rdat = 32'($urandom_range(0, 1));
      cyc("rand", rsel,
          (($urandom_range(0, 15) == 0) ? BASE + 32'h20 : BASE) + 32'(roff * 4) + 32'($urandom_range(0, 3)),
          rrw, rdat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
